// File: rtl/pc_unit_if.sv
// pc_unit_if: groups the fetch-stage control and the PC outputs exchanged
// between the next-PC logic (master) and the program-counter unit (slave).
interface pc_unit_if #(
  parameter int PC_W = 13
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            call;
  logic            ret;
  logic            exc;
  logic            eret;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic [PC_W-1:0] epc;
  logic            fetch_valid;
  logic [1:0]      state;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           call, ret, exc, eret, halt, resume,
    input  pc, pc_plus, epc, fetch_valid, state
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           call, ret, exc, eret, halt, resume,
    output pc, pc_plus, epc, fetch_valid, state
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with sequential increment, stall hold,
// jump/branch redirect, exception vectoring with EPC/ERET and a
// BOOT/RUN/HALT state machine.
// Optional feature: define PC_RAS_EN to compile in a RAS_DEPTH-entry
// return-address stack (call pushes pc_plus, ret pops). Without it, call
// behaves as jump and ret always uses jump_target.
module pc_unit #(
  parameter int PC_W      = 13,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int EXC_VEC   = 'h0100,
  parameter int RAS_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
  localparam logic [PC_W-1:0] RESET_V = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] EXC_V   = PC_W'(EXC_VEC);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] r_epc;
  logic [PC_W-1:0] w_epc_nxt;
  logic [PC_W-1:0] w_pc_plus;

  assign w_pc_plus       = r_pc + STEP_V;
  assign bus.pc          = r_pc;
  assign bus.pc_plus     = w_pc_plus;
  assign bus.epc         = r_epc;
  assign bus.state       = r_state;
  // Fetch is valid only while running and not held by stall or halt.
  assign bus.fetch_valid = (r_state == ST_RUN) && !bus.stall && !bus.halt;

`ifdef PC_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Entry 0 is the top of stack; pushing shifts older entries toward the
  // bottom so a push into a full stack drops the oldest address.
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [CNT_W-1:0] r_ras_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_ras_empty;

  assign w_ras_empty = (r_ras_cnt == {CNT_W{1'b0}});

  // Return-address stack storage and saturating occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ras_cnt <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= {PC_W{1'b0}};
    end else if (w_pop) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) r_ras[i] <= r_ras[i+1];
      r_ras[RAS_DEPTH-1] <= {PC_W{1'b0}};
      r_ras_cnt <= r_ras_cnt - CNT_W'(1);
    end else if (w_push) begin
      for (int i = 1; i < RAS_DEPTH; i++) r_ras[i] <= r_ras[i-1];
      r_ras[0] <= w_pc_plus;
      if (r_ras_cnt != CNT_MAX) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      else                      r_ras_cnt <= r_ras_cnt;
    end else begin
      r_ras_cnt <= r_ras_cnt;
    end
  end
`endif

  // State, PC and EPC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_V;
      r_epc   <= {PC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  // Next-state and next-PC selection; exc overrides everything in any state.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
`ifdef PC_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    if (bus.exc) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = EXC_V;
      w_epc_nxt   = r_pc;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (bus.halt) w_state_nxt = ST_HALT;
          else          w_state_nxt = ST_RUN;
          if (bus.eret) begin
            w_pc_nxt = r_epc;
          end else if (bus.stall || bus.halt) begin
            w_pc_nxt = r_pc;
          end else if (bus.ret) begin
`ifdef PC_RAS_EN
            if (!w_ras_empty) begin
              w_pc_nxt = r_ras[0];
              w_pop    = 1'b1;
            end else begin
              w_pc_nxt = bus.jump_target;
            end
`else
            w_pc_nxt = bus.jump_target;
`endif
          end else if (bus.jump || bus.call) begin
            w_pc_nxt = bus.jump_target;
`ifdef PC_RAS_EN
            w_push   = bus.call;
`endif
          end else if (bus.branch_taken) begin
            w_pc_nxt = bus.branch_target;
          end else begin
            w_pc_nxt = w_pc_plus;
          end
        end
        ST_HALT: begin
          if (bus.resume) w_state_nxt = ST_RUN;
          else            w_state_nxt = ST_HALT;
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus for pc_unit with a behavioural model that is
// compared on every falling edge, plus hand-computed literal expectations.
module tb_pc_unit;

  localparam int PC_W      = 13;
  localparam int STEP      = 1;
  localparam int RESET_VEC = 0;
  localparam int EXC_VEC   = 'h0100;
  localparam int RAS_DEPTH = 4;
  localparam int MASK      = (1 << PC_W) - 1;
`ifdef PC_RAS_EN
  localparam bit HAS_RAS = 1'b1;
`else
  localparam bit HAS_RAS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  pc_unit_if #(.PC_W(PC_W)) bus ();

  pc_unit #(
    .PC_W(PC_W), .STEP(STEP), .RESET_VEC(RESET_VEC),
    .EXC_VEC(EXC_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 BOOT, 1 RUN, 2 HALT; return stack as a queue.
  int m_pc  = RESET_VEC;
  int m_epc = 0;
  int m_st  = 0;
  int ras[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task model_step();
    if (reset) begin
      m_pc = RESET_VEC; m_epc = 0; m_st = 0; ras.delete();
    end else if (bus.exc) begin
      m_epc = m_pc; m_pc = EXC_VEC; m_st = 1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 2) begin
      if (bus.resume) m_st = 1;
    end else begin
      if (bus.halt) m_st = 2;
      if (bus.eret) m_pc = m_epc;
      else if (bus.stall || bus.halt) m_pc = m_pc;
      else if (bus.ret) begin
        if (HAS_RAS && ras.size() > 0) m_pc = ras.pop_front();
        else m_pc = int'(bus.jump_target);
      end else if (bus.jump || bus.call) begin
        if (HAS_RAS && bus.call) begin
          ras.push_front((m_pc + STEP) & MASK);
          if (ras.size() > RAS_DEPTH) void'(ras.pop_back());
        end
        m_pc = int'(bus.jump_target);
      end else if (bus.branch_taken) m_pc = int'(bus.branch_target);
      else m_pc = (m_pc + STEP) & MASK;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pc",          int'(bus.pc),          m_pc);
      chk("pc_plus",     int'(bus.pc_plus),     (m_pc + STEP) & MASK);
      chk("epc",         int'(bus.epc),         m_epc);
      chk("state",       int'(bus.state),       m_st);
      chk("fetch_valid", int'(bus.fetch_valid),
          int'(m_st == 1 && !bus.stall && !bus.halt));
    end
  end

  task automatic idle();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.jump_target = '0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.exc = 1'b0; bus.eret = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input int t);
    idle(); bus.jump = 1'b1; bus.jump_target = PC_W'(t); cyc(); idle();
  endtask

  task automatic do_call(input int t);
    idle(); bus.call = 1'b1; bus.jump_target = PC_W'(t); cyc(); idle();
  endtask

  task automatic do_ret(input int t, input int exp, input string nm);
    idle(); bus.ret = 1'b1; bus.jump_target = PC_W'(t); cyc();
    chk(nm, int'(bus.pc), exp); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    // Reset and boot sequence.
    cyc(); cyc();
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_epc", int'(bus.epc), 0);
    chk("boot_fv", int'(bus.fetch_valid), 0);
    reset = 1'b0;
    cyc();
    chk("boot_pc", int'(bus.pc), 0);
    chk("run_state", int'(bus.state), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("inc_pc", int'(bus.pc), i);
    end
    // Wrap-around.
    do_jump('h1FFF);
    chk("wrap_top", int'(bus.pc), 'h1FFF);
    chk("wrap_plus", int'(bus.pc_plus), 0);
    cyc();
    chk("wrap_zero", int'(bus.pc), 0);
    // Priority.
    do_jump(5);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = PC_W'(9);
    cyc();
    chk("stall_hold", int'(bus.pc), 5);
    chk("stall_fv", int'(bus.fetch_valid), 0);
    bus.stall = 1'b0;
    cyc();
    chk("branch", int'(bus.pc), 9);
    bus.jump = 1'b1; bus.jump_target = PC_W'(20); bus.branch_target = PC_W'(30);
    cyc();
    chk("jump_over_branch", int'(bus.pc), 20);
    idle();
    // Exceptions.
    do_jump(7);
    bus.exc = 1'b1; bus.stall = 1'b1;
    cyc();
    chk("exc_pc", int'(bus.pc), 'h100);
    chk("exc_epc", int'(bus.epc), 7);
    idle();
    cyc(); cyc();
    chk("handler_pc", int'(bus.pc), 'h102);
    bus.eret = 1'b1;
    cyc();
    chk("eret_pc", int'(bus.pc), 7);
    idle();
    do_jump('h102);
    bus.exc = 1'b1; bus.eret = 1'b1;
    cyc();
    chk("exc_eret_pc", int'(bus.pc), 'h100);
    chk("exc_eret_epc", int'(bus.epc), 'h102);
    idle();
    // Halt / resume.
    do_jump(4);
    bus.halt = 1'b1;
    cyc();
    idle();
    chk("halt_state", int'(bus.state), 2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_pc", int'(bus.pc), 4);
      chk("halt_fv", int'(bus.fetch_valid), 0);
    end
    bus.resume = 1'b1;
    cyc();
    idle();
    chk("resume_state", int'(bus.state), 1);
    cyc();
    chk("resume_pc", int'(bus.pc), 5);
    // Exception taken from HALT.
    bus.halt = 1'b1;
    cyc();
    idle();
    bus.exc = 1'b1;
    cyc();
    idle();
    chk("halt_exc_pc", int'(bus.pc), 'h100);
    chk("halt_exc_epc", int'(bus.epc), 5);
    chk("halt_exc_state", int'(bus.state), 1);
    // Asynchronous reset in the middle of a HALT cycle.
    bus.halt = 1'b1;
    cyc();
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", int'(bus.pc), 0);
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_epc", int'(bus.epc), 0);
    #2 reset = 1'b0;
    // Exception taken from BOOT.
    bus.exc = 1'b1;
    cyc();
    idle();
    chk("boot_exc_pc", int'(bus.pc), 'h100);
    chk("boot_exc_epc", int'(bus.epc), 0);
    chk("boot_exc_state", int'(bus.state), 1);
    cyc();
    // Return handling.
    do_ret(99, 99, "ret_empty");
    do_jump(10);
    do_call(30); do_call(50); do_call(70);
    chk("call_pc", int'(bus.pc), 70);
    do_ret(0, HAS_RAS ? 51 : 0, "ret1");
    do_ret(0, HAS_RAS ? 31 : 0, "ret2");
    do_ret(0, HAS_RAS ? 11 : 0, "ret3");
    do_ret(99, 99, "ret4_empty");
    for (int i = 2; i <= 6; i++) do_call(i * 100);
    do_ret(0, HAS_RAS ? 501 : 0, "deep1");
    do_ret(0, HAS_RAS ? 401 : 0, "deep2");
    do_ret(0, HAS_RAS ? 301 : 0, "deep3");
    do_ret(0, HAS_RAS ? 201 : 0, "deep4");
    do_ret(0, 0, "deep_lost");
    // Stalled call must not push.
    bus.call = 1'b1; bus.stall = 1'b1; bus.jump_target = PC_W'(700);
    cyc();
    idle();
    do_ret(9, 9, "stalled_call");
    // call and ret together: ret wins.
    do_call(700);
    bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = PC_W'(800);
    cyc();
    chk("call_ret", int'(bus.pc), HAS_RAS ? 10 : 800);
    idle();
    do_ret(5, 5, "call_ret_nopush");
    // exc/eret leave the stack alone.
    do_call(40);
    bus.exc = 1'b1;
    cyc();
    idle();
    bus.eret = 1'b1;
    cyc();
    idle();
    chk("eret_back", int'(bus.pc), 40);
    do_ret(0, HAS_RAS ? 6 : 0, "ret_after_exc");
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It replaces the bare PC register. It adds:
- sequential increment
- stall hold
- jump/branch redirect
- exception vectoring with a saved EPC and ERET return
- a halt/resume state machine

It sits between the next-PC logic of the decode/execute stages and the instruction-memory address port.

## Interface
Parameters:
- PC_W, 13, PC width in bits (word address into instruction memory)
- STEP, 1, sequential increment added each advancing cycle
- RESET_VEC, 0, PC value after reset
- EXC_VEC, 'h0100, exception handler address
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC this cycle
- branch_taken  in  1  redirect to branch_target
- branch_target  in  PC_W  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  PC_W  jump destination; register value for returns
- call  in  1  jump that is a subroutine call (jal); also redirects to jump_target
- ret  in  1  subroutine return (jr $ra)
- exc  in  1  exception request
- eret  in  1  return from exception
- halt  in  1  enter HALT
- resume  in  1  leave HALT
- pc  out  PC_W  current fetch address
- pc_plus  out  PC_W  pc + STEP, modulo 2^PC_W
- epc  out  PC_W  PC saved at the last exception
- fetch_valid  out  1  pc is a valid fetch this cycle
- state  out  2  00 BOOT, 01 RUN, 10 HALT

## Operation
Reset values: pc=RESET_VEC, epc=0, state=BOOT, fetch_valid=0. The RAS, when present, is empty.

State machine:
- BOOT → RUN on the next clock unconditionally. pc holds RESET_VEC. All inputs except exc are ignored.
- RUN → HALT when halt=1 and exc=0. pc holds; halt takes effect at the same priority as stall.
- HALT → RUN on resume=1. pc holds in HALT.
- exc in any state → RUN.

Next-PC priority in RUN, highest first:
1. exc: pc←EXC_VEC, epc←pc. In BOOT or HALT, epc←pc as well.
2. eret: pc←epc.
3. stall or halt: pc holds.
4. ret: pc←jump_target, or the RAS top (see Configuration).
5. jump or call: pc←jump_target.
6. branch_taken: pc←branch_target.
7. Otherwise: pc←pc+STEP.

Rules:
- All arithmetic wraps modulo 2^PC_W. Carry out is discarded.
- fetch_valid=1 only in RUN with stall=0 and halt=0, evaluated combinationally from state and inputs.
- A second exc while handling the first overwrites epc. There is no nesting.
- Simultaneous jump and branch_taken: jump wins.
- Simultaneous exc and eret: exc wins, and epc←current pc.

## Timing
- Single cycle. The redirect or increment appears on pc one clock after the inputs are sampled.
- pc_plus is combinational from pc.
- Asserting reset at any time forces the reset values immediately, independent of clk. This includes mid-stall, in HALT, and mid-exception.
- After reset deasserts:
  - first edge: BOOT → RUN, pc=RESET_VEC.
  - second edge: first advance to RESET_VEC+STEP, if the inputs are idle.

## Configuration
PC_RAS_EN:
- Defined: a RAS_DEPTH-entry return-address stack is compiled in.
  - call pushes pc_plus.
  - ret pops, and pc←popped value when the stack is non-empty. When empty, pc←jump_target.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - call and ret in the same cycle: ret is taken, the stack pops, and no push occurs.
  - Stalled or halted cycles do not modify the stack.
  - exc and eret do not modify the stack.
- Undefined: no stack storage exists. call behaves exactly as jump, and ret always uses jump_target.

## Test plan
- Reset: reset=1 then released, idle inputs → pc=0 for 2 edges (reset, BOOT), then 1, 2, 3. fetch_valid=0 in BOOT.
- Wrap-around: drive jump_target='h1FFF with jump=1 → pc='h1FFF, then the next idle edge gives pc='h0000.
- Priority: pc=5, assert stall=1 with branch_taken=1 and branch_target=9 → pc stays 5. Drop stall, keep branch → pc=9. Assert jump (jump_target=20) and branch_taken (branch_target=30) together → pc=20.
- Exception:
  - At pc=7, exc=1 with stall=1 → pc='h0100, epc=7.
  - Two advances later, eret=1 → pc=7.
  - exc and eret together at pc='h0102 → pc='h0100, epc='h0102.
- Halt and async reset:
  - halt at pc=4 → state=HALT, pc=4 held 3 cycles, fetch_valid=0.
  - resume → pc=5 on the following edge.
  - reset pulsed mid-HALT, between clock edges → pc=0 and state=BOOT immediately.
- RAS (PC_RAS_EN defined):
  - Calls at pc=10, 30, 50 (targets 30, 50, 70) push 11, 31, 51.
  - Three rets (jump_target=0) → pc=51, 31, 11.
  - A fourth ret with jump_target=99 → pc=99.
  - Five nested calls with RAS_DEPTH=4 → the oldest return address is lost.
  - With PC_RAS_EN undefined, ret with jump_target=99 → pc=99.
